// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue control for the multiply/divide unit.
// Issues start/op/mthi/mtlo, times the busy window, stalls dependents.
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic        e_flush,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        md_wr_hi,
    output logic        md_wr_lo,
    output logic        md_busy,
    output logic        stall_e,
    output logic [31:0] mf_data,
    output logic [15:0] md_issued
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [15:0]      issued_q;
    logic [15:0]      issued_nxt;

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic is_mfhi;
    logic is_mflo;
    logic use_md;
    logic go;

    // Decode the E-stage HI/LO instruction class; codes 0 and 9-15 are none.
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        is_mfhi = 1'b0;
        is_mflo = 1'b0;
        case (e_md_op)
            4'd1, 4'd2: is_mul  = 1'b1;
            4'd3, 4'd4: is_div  = 1'b1;
            4'd5:       is_mthi = 1'b1;
            4'd6:       is_mtlo = 1'b1;
            4'd7:       is_mfhi = 1'b1;
            4'd8:       is_mflo = 1'b1;
            default:    ;
        endcase
    end

    // Any HI/LO user must wait for the in-flight operation; flush does
    // not mask the stall, it only blocks issue.
    assign use_md = e_valid & (is_mul | is_div | is_mthi | is_mtlo
                               | is_mfhi | is_mflo);
    assign md_busy   = (state == BUSY);
    assign stall_e   = use_md & md_busy;
    assign go        = use_md & ~stall_e & ~e_flush;
    assign md_issued = issued_q;

    // State, busy counter and issue counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            issued_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            issued_q <= issued_nxt;
        end
    end

    // Next-state: load the latency on a start, count down while busy.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        issued_nxt = issued_q;
        unique case (state)
            IDLE: begin
                if (md_start) begin
                    state_nxt  = BUSY;
                    cnt_nxt    = is_mul ? CNT_W'(MULT_CYCLES)
                                        : CNT_W'(DIV_CYCLES);
                    issued_nxt = issued_q + 16'd1;
                end
            end
            BUSY: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs: unit controls and HI/LO forwarding select.
    always_comb begin
        md_start = 1'b0;
        md_op    = 3'd0;
        md_wr_hi = 1'b0;
        md_wr_lo = 1'b0;
        mf_data  = 32'd0;
        if (go && (state == IDLE) && (is_mul || is_div)) begin
            md_start = 1'b1;
            md_op    = e_md_op[2:0] - 3'd1;
        end
        md_wr_hi = go & is_mthi;
        md_wr_lo = go & is_mtlo;
        if (is_mfhi) begin
            mf_data = md_hi;
        end else if (is_mflo) begin
            mf_data = md_lo;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: scoreboard bench for md_issue_ctrl.
// Expected outputs are queued at drive time and popped at the falling edge.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic        e_flush;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_wr_hi;
    logic        md_wr_lo;
    logic        md_busy;
    logic        stall_e;
    logic [31:0] mf_data;
    logic [15:0] md_issued;

    always #5 clk = ~clk;

    md_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_md_op   (e_md_op),
        .e_flush   (e_flush),
        .md_hi     (md_hi),
        .md_lo     (md_lo),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_wr_hi  (md_wr_hi),
        .md_wr_lo  (md_wr_lo),
        .md_busy   (md_busy),
        .stall_e   (stall_e),
        .mf_data   (mf_data),
        .md_issued (md_issued)
    );

    typedef struct packed {
        logic        start;
        logic [2:0]  op;
        logic        wr_hi;
        logic        wr_lo;
        logic        busy;
        logic        stall;
        logic [31:0] mf;
        logic [15:0] issued;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        m_busy;
    int          m_cnt;
    logic [15:0] m_issued;

    function automatic exp_t obs();
        exp_t o;
        o = {md_start, md_op, md_wr_hi, md_wr_lo, md_busy, stall_e,
             mf_data, md_issued};
        return o;
    endfunction

    function automatic logic is_use(logic v, logic [3:0] op);
        return v && (op >= 4'd1) && (op <= 4'd8);
    endfunction

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic fl, input logic rst);
        exp_t e;
        logic st;
        logic g;
        reset   = rst;
        e_valid = v;
        e_md_op = op;
        e_flush = fl;
        st = is_use(v, op) && m_busy;
        g  = is_use(v, op) && !st && !fl;
        e = '0;
        e.start  = g && (op >= 4'd1) && (op <= 4'd4);
        e.op     = e.start ? 3'(op - 4'd1) : 3'd0;
        e.wr_hi  = g && (op == 4'd5);
        e.wr_lo  = g && (op == 4'd6);
        e.busy   = m_busy;
        e.stall  = st;
        e.mf     = (op == 4'd7) ? md_hi : (op == 4'd8) ? md_lo : 32'd0;
        e.issued = m_issued;
        q.push_back(e);
    endtask

    task automatic adv();
        logic g;
        g = is_use(e_valid, e_md_op) && !m_busy && !e_flush;
        if (reset) begin
            m_busy   = 1'b0;
            m_cnt    = 0;
            m_issued = 16'd0;
        end else if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_busy = 1'b0;
        end else if (g && e_md_op >= 4'd1 && e_md_op <= 4'd4) begin
            m_busy   = 1'b1;
            m_cnt    = (e_md_op <= 4'd2) ? 5 : 10;
            m_issued = m_issued + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t e;
        exp_t o;
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        e = q.pop_front();
        o = obs();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL rst_cycle got %h expected %h", o, e);
        end
        adv();
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t o;
        reset = 1'b1; e_valid = 1'b0; e_md_op = 4'd0; e_flush = 1'b0;
        md_hi = 32'h0; md_lo = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        m_busy = 1'b0; m_cnt = 0; m_issued = 16'd0;
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'd0, 1'b0, c == 0);
            @(negedge clk);
            e = q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset c%0d got %h expected %h", c, o, e);
            end
            n_tests++;
            if ({md_busy, stall_e, md_start, md_issued} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_zero c%0d got busy=%b stall=%b start=%b iss=%h required 0",
                         c, md_busy, stall_e, md_start, md_issued);
            end
            adv();
        end
    endtask

    task automatic test_mult_mflo();
        exp_t e;
        exp_t o;
        logic [3:0] op;
        do_reset();
        md_hi = 32'h1111_2222;
        md_lo = 32'hA5A5_1234;
        for (int c = 0; c < 8; c++) begin
            op = (c == 0) ? 4'd1 : (c <= 6) ? 4'd8 : 4'd0;
            drive(c <= 6, op, 1'b0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mult_mflo c%0d got %h expected %h", c, o, e);
            end
            if (c == 0) begin
                n_tests++;
                if (md_start !== 1'b1 || md_op !== 3'd0) begin
                    n_fail++;
                    $display("FAIL mult_start got %b/%0d required 1/0", md_start, md_op);
                end
            end
            if (c >= 1 && c <= 6) begin
                n_tests++;
                if (stall_e !== (c <= 5)) begin
                    n_fail++;
                    $display("FAIL mflo_stall c%0d got %b required %b", c, stall_e, c <= 5);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (mf_data !== 32'hA5A5_1234) begin
                    n_fail++;
                    $display("FAIL mflo_data got %h required a5a51234", mf_data);
                end
            end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t o;
        logic [3:0] op;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            op = (c == 0) ? 4'd4 : (c <= 11) ? 4'd1 : 4'd0;
            drive(c <= 11, op, 1'b0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b c%0d got %h expected %h", c, o, e);
            end
            n_tests++;
            if (md_busy !== ((c >= 1 && c <= 10) || (c >= 12 && c <= 16))) begin
                n_fail++;
                $display("FAIL b2b_busy c%0d got %b", c, md_busy);
            end
            if (c == 11) begin
                n_tests++;
                if (md_start !== 1'b1 || md_op !== 3'd0) begin
                    n_fail++;
                    $display("FAIL b2b_start got %b/%0d required 1/0", md_start, md_op);
                end
            end
            if (c == 12) begin
                n_tests++;
                if (md_issued !== 16'd2) begin
                    n_fail++;
                    $display("FAIL b2b_issued got %0d required 2", md_issued);
                end
            end
            adv();
        end
    endtask

    task automatic test_mthi();
        exp_t e;
        exp_t o;
        logic [3:0] op;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            op = (c == 0) ? 4'd5 : (c == 1) ? 4'd6 : (c == 2) ? 4'd1
               : (c <= 8) ? 4'd5 : 4'd0;
            drive(c <= 8, op, 1'b0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mthi c%0d got %h expected %h", c, o, e);
            end
            if (c == 0 || (c >= 3 && c <= 8)) begin
                n_tests++;
                if (md_wr_hi !== (c == 0 || c == 8) || stall_e !== (c >= 3 && c <= 7)) begin
                    n_fail++;
                    $display("FAIL mthi_ctl c%0d got wr_hi=%b stall=%b", c, md_wr_hi, stall_e);
                end
            end
            if (c == 1) begin
                n_tests++;
                if (md_wr_lo !== 1'b1 || md_wr_hi !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mtlo got wr_lo=%b wr_hi=%b required 1/0", md_wr_lo, md_wr_hi);
                end
            end
            adv();
        end
    endtask

    task automatic test_flush();
        exp_t e;
        exp_t o;
        logic [3:0] op;
        logic       v;
        do_reset();
        md_hi = 32'hDEAD_0001;
        md_lo = 32'hBEEF_0002;
        for (int c = 0; c < 14; c++) begin
            v  = (c == 0) || (c == 2) || (c == 5);
            op = (c == 0 || c == 2) ? 4'd3 : (c == 5) ? 4'd8 : 4'd0;
            drive(v, op, c == 0 || c == 5, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush c%0d got %h expected %h", c, o, e);
            end
            if (c <= 2) begin
                n_tests++;
                if (md_start !== (c == 2) || md_busy !== 1'b0 || md_issued !== 16'd0) begin
                    n_fail++;
                    $display("FAIL flush_start c%0d got start=%b busy=%b iss=%0d",
                             c, md_start, md_busy, md_issued);
                end
            end
            if (c == 5) begin
                n_tests++;
                if (stall_e !== 1'b1) begin
                    n_fail++;
                    $display("FAIL flush_stall got %b required 1", stall_e);
                end
            end
            if (c >= 12) begin
                n_tests++;
                if (md_busy !== (c == 12) || md_issued !== 16'd1) begin
                    n_fail++;
                    $display("FAIL flush_busy c%0d got busy=%b iss=%0d", c, md_busy, md_issued);
                end
            end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        exp_t o;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(c == 0 || c == 6, (c == 0 || c == 6) ? 4'd1 : 4'd0,
                  1'b0, c == 4);
            @(negedge clk);
            e = q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid c%0d got %h expected %h", c, o, e);
            end
            if (c == 5) begin
                n_tests++;
                if (md_busy !== 1'b0 || md_issued !== 16'd0) begin
                    n_fail++;
                    $display("FAIL rst_mid_clear got busy=%b iss=%0d required 0/0",
                             md_busy, md_issued);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (md_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_mid_restart got %b required 1", md_start);
                end
            end
            adv();
        end
    endtask

    task automatic test_wrap_and_bad_code();
        exp_t e;
        exp_t o;
        logic [3:0] op;
        do_reset();
        md_hi = 32'h0BAD_F00D;
        md_lo = 32'h600D_CAFE;
        for (int c = 0; c < 9; c++) begin
            op = (c == 1) ? 4'd2 : (c == 3 || c == 7) ? 4'hC : 4'd0;
            drive(c == 1 || c == 3 || c == 7, op, 1'b0, 1'b0);
            @(negedge clk);
            e = q.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap c%0d got %h expected %h", c, o, e);
            end
            if (c == 0) begin
                dut.issued_q = 16'hFFFF;
                m_issued     = 16'hFFFF;
            end
            if (c == 2) begin
                n_tests++;
                if (md_issued !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL wrap_issued got %h required 0000", md_issued);
                end
            end
            if (c == 3 || c == 7) begin
                n_tests++;
                if ({stall_e, md_start, md_op, md_wr_hi, md_wr_lo} !== 7'd0
                    || mf_data !== 32'd0) begin
                    n_fail++;
                    $display("FAIL bad_code c%0d got stall=%b start=%b op=%0d hi=%b lo=%b mf=%h",
                             c, stall_e, md_start, md_op, md_wr_hi, md_wr_lo, mf_data);
                end
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_mult_mflo();
        test_back_to_back();
        test_mthi();
        test_flush();
        test_reset_mid();
        test_wrap_and_bad_code();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
